// File: rtl/keypad_pkg.sv
// keypad_pkg: shared state encoding and key-field constants for the keypad emulator
package keypad_pkg;
  localparam int NUM_ROWS    = 4;
  localparam int NUM_COLS    = 4;
  localparam int KEY_ROW_MSB = 3;
  localparam int KEY_ROW_LSB = 2;
  localparam int KEY_COL_MSB = 1;
  localparam int KEY_COL_LSB = 0;
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MAKE  = 3'd1,
    ST_HOLD  = 3'd2,
    ST_BREAK = 3'd3,
    ST_GAP   = 3'd4,
    ST_DONE  = 3'd5
  } state_t;
endpackage

// File: rtl/keypad_emulator_switch_matrix.sv
// keypad_switch_matrix: combinational row-to-column reflection through the single closed contact
module keypad_switch_matrix
  import keypad_pkg::*;
(
  input  logic                contact,
  input  logic [3:0]          key,
  input  logic [NUM_ROWS-1:0] row,
  output logic [NUM_COLS-1:0] col
);
  logic row_hit;
  assign row_hit = contact && row[key[KEY_ROW_MSB:KEY_ROW_LSB]];
  for (genvar j = 0; j < NUM_COLS; j++) begin : g_col
    assign col[j] = row_hit && (key[KEY_COL_MSB:KEY_COL_LSB] == 2'(j));
  end
endmodule

// File: rtl/keypad_emulator.sv
// keypad_emulator: scripted 4x4 keypad press/hold/release/gap sequencer with switch-matrix loopback.
// Define KEYPAD_EMU_BOUNCE_EN to add contact bounce bursts at make and break.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int GAP_CYCLES = 16
`ifdef KEYPAD_EMU_BOUNCE_EN
  , parameter int BOUNCE_CYCLES = 8
  , parameter int BOUNCE_PERIOD = 2
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_valid,
  input  logic [3:0]  key_idx,
  input  logic [15:0] hold_len,
  input  logic        cancel,
  output logic        key_ready,
  input  logic        row0,
  input  logic        row1,
  input  logic        row2,
  input  logic        row3,
  output logic        c0,
  output logic        c1,
  output logic        c2,
  output logic        c3,
  output logic        pressed,
  output logic        done
);
  state_t state_q, state_d;
  logic [15:0] hold_q, hold_d, gap_q, gap_d;
  logic [3:0] key_q, key_d;
  logic contact;
  logic [NUM_COLS-1:0] col;
  localparam logic [15:0] GAP_LOAD = 16'(GAP_CYCLES - 1);
`ifdef KEYPAD_EMU_BOUNCE_EN
  logic [15:0] bnc_q, bnc_d;
  localparam logic [15:0] BNC_LAST = 16'(BOUNCE_CYCLES - 1);
  // Burst starts closed and flips every BOUNCE_PERIOD cycles.
  assign contact = (state_q == ST_HOLD) ||
                   ((state_q == ST_MAKE || state_q == ST_BREAK) && ((int'(bnc_q) / BOUNCE_PERIOD) % 2 == 0));
`else
  assign contact = (state_q == ST_HOLD);
`endif
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    key_d   = key_q;
`ifdef KEYPAD_EMU_BOUNCE_EN
    bnc_d   = bnc_q;
`endif
    case (state_q)
      ST_IDLE: if (key_valid) begin
        key_d  = key_idx;
        hold_d = (hold_len == 16'd0) ? 16'd1 : hold_len;
`ifdef KEYPAD_EMU_BOUNCE_EN
        bnc_d   = 16'd0;
        state_d = ST_MAKE;
`else
        state_d = ST_HOLD;
`endif
      end
`ifdef KEYPAD_EMU_BOUNCE_EN
      ST_MAKE: if (cancel) begin
        state_d = ST_GAP;
        gap_d   = GAP_LOAD;
      end else if (bnc_q == BNC_LAST) state_d = ST_HOLD;
      else bnc_d = bnc_q + 16'd1;
      ST_BREAK: if (cancel || bnc_q == BNC_LAST) begin
        state_d = ST_GAP;
        gap_d   = GAP_LOAD;
      end else bnc_d = bnc_q + 16'd1;
`endif
      ST_HOLD: if (cancel) begin
        state_d = ST_GAP;
        gap_d   = GAP_LOAD;
      end else if (hold_q == 16'd1) begin
`ifdef KEYPAD_EMU_BOUNCE_EN
        state_d = ST_BREAK;
        bnc_d   = 16'd0;
`else
        state_d = ST_GAP;
        gap_d   = GAP_LOAD;
`endif
      end else hold_d = hold_q - 16'd1;
      ST_GAP: if (gap_q == 16'd0) state_d = ST_DONE;
      else gap_d = gap_q - 16'd1;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      hold_q  <= 16'd0;
      gap_q   <= 16'd0;
      key_q   <= 4'd0;
`ifdef KEYPAD_EMU_BOUNCE_EN
      bnc_q   <= 16'd0;
`endif
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      key_q   <= key_d;
`ifdef KEYPAD_EMU_BOUNCE_EN
      bnc_q   <= bnc_d;
`endif
    end
  end
  keypad_switch_matrix u_matrix (
    .contact (contact),
    .key     (key_q),
    .row     ({row3, row2, row1, row0}),
    .col     (col)
  );
  assign {c3, c2, c1, c0} = col;
  assign pressed   = contact;
  assign key_ready = (state_q == ST_IDLE);
  assign done      = (state_q == ST_DONE);
endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: randomized and directed presses checked against a cycle-timeline model of the keypad.
module tb_keypad_emulator;
  localparam int GAP = 16;
  localparam int BP  = 2;
`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam int MK = 8;
`else
  localparam int MK = 0;
`endif
  logic clk = 1'b0;
  logic reset, key_valid, cancel;
  logic [3:0] key_idx, rows;
  logic [15:0] hold_len;
  logic key_ready, c0, c1, c2, c3, pressed, done;
  int vecs = 0;
  int errs = 0;
  always #5 clk = ~clk;
  keypad_emulator dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_idx(key_idx), .hold_len(hold_len),
    .cancel(cancel), .key_ready(key_ready), .row0(rows[0]), .row1(rows[1]), .row2(rows[2]),
    .row3(rows[3]), .c0(c0), .c1(c1), .c2(c2), .c3(c3), .pressed(pressed), .done(done)
  );
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic bit bounce_closed(input int k);
    return ((k / BP) % 2) == 0;
  endfunction
  task automatic press(input logic [3:0] k, input logic [15:0] hl, input int cancel_at,
                       input logic [3:0] rfix, input bit rrand, input bit keep);
    int eff, len, brk, gs, endc;
    bit canc, ct;
    logic [3:0] ec;
    chk("ready_before_press", 16'(key_ready), 16'd1);
    key_valid = 1'b1;
    key_idx   = k;
    hold_len  = hl;
    rows      = rrand ? 4'($urandom) : rfix;
    eff  = (hl == 16'd0) ? 1 : int'(hl);
    canc = cancel_at > 0 && cancel_at <= eff;
    len  = canc ? cancel_at : eff;
    brk  = canc ? 0 : MK;
    gs   = MK + len + brk + 1;
    endc = MK + len + brk + GAP;
    for (int t = 1; t <= endc + 2; t++) begin
      @(negedge clk);
      if (t <= MK) ct = bounce_closed(t - 1);
      else if (t <= MK + len) ct = 1'b1;
      else if (t < gs) ct = bounce_closed(t - MK - len - 1);
      else ct = 1'b0;
      ec = (ct && rows[k[3:2]]) ? (4'b0001 << k[1:0]) : 4'b0000;
      chk("pressed", 16'(pressed), 16'(ct));
      chk("columns", 16'({c3, c2, c1, c0}), 16'(ec));
      chk("done", 16'(done), 16'(t == endc + 1));
      chk("key_ready", 16'(key_ready), 16'(t == endc + 2));
      if (!keep) key_valid = 1'b0;
      if (t < endc + 2) begin
        key_idx  = 4'($urandom);
        hold_len = 16'($urandom);
        rows     = rrand ? 4'($urandom) : rfix;
      end
      cancel = (canc && t == MK + cancel_at) || (t >= gs && $urandom_range(0, 3) == 0);
    end
  endtask
  initial begin
    reset = 1'b1; key_valid = 1'b0; cancel = 1'b0; key_idx = 4'd0; hold_len = 16'd0; rows = 4'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_ready", 16'(key_ready), 16'd1);
    chk("reset_cols", 16'({c3, c2, c1, c0}), 16'd0);
    chk("reset_pressed", 16'(pressed), 16'd0);
    chk("reset_done", 16'(done), 16'd0);
    press(4'b0110, 16'd5, 0, 4'b0010, 1'b0, 1'b0);
    press(4'b0110, 16'd5, 0, 4'b0001, 1'b0, 1'b0);
    press(4'b1011, 16'd0, 0, 4'b1111, 1'b0, 1'b1);
    press(4'b0001, 16'd100, 10, 4'b1111, 1'b0, 1'b0);
    key_valid = 1'b1; key_idx = 4'hF; hold_len = 16'd50; rows = 4'hF; cancel = 1'b0;
    repeat (12) @(negedge clk);
    key_valid = 1'b0;
    chk("mid_hold_pressed", 16'(pressed), 16'd1);
    chk("mid_hold_c3", 16'(c3), 16'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_ready", 16'(key_ready), 16'd1);
    chk("rst_mid_pressed", 16'(pressed), 16'd0);
    chk("rst_mid_cols", 16'({c3, c2, c1, c0}), 16'd0);
    chk("rst_mid_done", 16'(done), 16'd0);
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_done", 16'(done), 16'd0);
      chk("post_rst_ready", 16'(key_ready), 16'd1);
    end
    for (int i = 0; i < 20; i++)
      press(4'($urandom), 16'($urandom_range(0, 40)),
            ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 45)) : 0,
            4'd0, 1'b1, 1'($urandom));
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
